delay_pulse_scheduler: RTL and testbench

DELAY_PULSE_SCHEDULER -- requirements
Module: delay_pulse_scheduler

---
 rtl/fd_timestamp_pkg.sv | 28 ++
 rtl/delay_pulse_scheduler_if.sv | 39 +++
 rtl/timestamp_normalizer.sv | 57 +++++
 rtl/delay_pulse_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_delay_pulse_scheduler.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/fd_timestamp_pkg.sv
// Shared timestamp types for the fine-delay scheduler: timestamp struct,
// fine-step range, scheduler state encoding and a time-ordering helper.
package fd_timestamp_pkg;

    localparam int unsigned c_frac_range = 4096;

    typedef struct packed {
        logic [31:0] utc;
        logic [27:0] coarse;
        logic [11:0] frac;
    } t_timestamp;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        WAIT_START,
        WAIT_END
    } t_state;

    // True when time a lies strictly after time b (UTC first, then coarse).
    function automatic logic ts_later(input logic [31:0] a_utc,
                                      input logic [27:0] a_coarse,
                                      input logic [31:0] b_utc,
                                      input logic [27:0] b_coarse);
        return (a_utc > b_utc) || ((a_utc == b_utc) && (a_coarse > b_coarse));
    endfunction

endpackage

// File: rtl/delay_pulse_scheduler_if.sv
// Tag, delay, local time base and pulse/status signals of one scheduler channel.
interface delay_pulse_scheduler_if;

    logic        enable_i;
    logic        tag_valid_p1_i;
    logic [31:0] tag_utc_i;
    logic [27:0] tag_coarse_i;
    logic [11:0] tag_frac_i;
    logic [31:0] delay_utc_i;
    logic [27:0] delay_coarse_i;
    logic [11:0] delay_frac_i;
    logic [15:0] width_i;
    logic [31:0] cntr_utc_i;
    logic [27:0] cntr_coarse_i;

    logic        pulse_start_p1_o;
    logic        pulse_end_p1_o;
    logic [11:0] pulse_frac_o;
    logic        busy_o;
    logic        missed_p1_o;
    logic        dropped_p1_o;

    modport master (
        output enable_i, tag_valid_p1_i, tag_utc_i, tag_coarse_i, tag_frac_i,
               delay_utc_i, delay_coarse_i, delay_frac_i, width_i,
               cntr_utc_i, cntr_coarse_i,
        input  pulse_start_p1_o, pulse_end_p1_o, pulse_frac_o, busy_o,
               missed_p1_o, dropped_p1_o
    );

    modport slave (
        input  enable_i, tag_valid_p1_i, tag_utc_i, tag_coarse_i, tag_frac_i,
               delay_utc_i, delay_coarse_i, delay_frac_i, width_i,
               cntr_utc_i, cntr_coarse_i,
        output pulse_start_p1_o, pulse_end_p1_o, pulse_frac_o, busy_o,
               missed_p1_o, dropped_p1_o
    );

endinterface

// File: rtl/timestamp_normalizer.sv
// Registered (utc, coarse) + (utc, coarse) + carry addition, with the coarse
// field folded back below g_coarse_range and the overflow carried into UTC.
module timestamp_normalizer #(
    parameter int unsigned g_coarse_range = 125000000,
    parameter int unsigned g_b_w          = 28,
    parameter bit          g_multi_wrap   = 1'b0
) (
    input  logic             clk_ref_i,
    input  logic             rst_n_i,
    input  logic             load,
    input  logic [31:0]      a_utc,
    input  logic [27:0]      a_coarse,
    input  logic [31:0]      b_utc,
    input  logic [g_b_w-1:0] b_coarse,
    input  logic             carry,
    output logic [31:0]      sum_utc,
    output logic [27:0]      sum_coarse
);

    localparam int unsigned c_sum_w = 30;
    localparam logic [c_sum_w-1:0] c_range = c_sum_w'(g_coarse_range);

    logic [c_sum_w-1:0] raw;
    logic [c_sum_w-1:0] wraps;
    logic [27:0]        rem;

    assign raw = c_sum_w'(a_coarse) + c_sum_w'(b_coarse) + c_sum_w'(carry);

    // The b operand may span several seconds when it carries a pulse width,
    // so that variant needs a true quotient instead of one conditional subtract.
    generate
        if (g_multi_wrap) begin : g_div
            assign wraps = raw / c_range;
            assign rem   = 28'(raw % c_range);
        end else begin : g_sub
            always_comb begin
                wraps = '0;
                rem   = 28'(raw);
                if (raw >= c_range) begin
                    wraps = c_sum_w'(1);
                    rem   = 28'(raw - c_range);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_ref_i) begin
        if (!rst_n_i) begin
            sum_utc    <= '0;
            sum_coarse <= '0;
        end else if (load) begin
            sum_utc    <= a_utc + b_utc + 32'(wraps);
            sum_coarse <= rem;
        end
    end

endmodule

// File: rtl/delay_pulse_scheduler.sv
// Single-channel delayed pulse scheduler: tag + delay gives a start time, start
// + width an end time; both are matched against the local time base.
module delay_pulse_scheduler
    import fd_timestamp_pkg::*;
#(
    parameter int unsigned g_coarse_range = 125000000,
    parameter int unsigned g_frac_range   = c_frac_range
) (
    input logic                    clk_ref_i,
    input logic                    rst_n_i,
    delay_pulse_scheduler_if.slave bus
);

    t_state      state;
    t_state      state_nxt;
    logic        calc_phase;

    t_timestamp  tag_r;
    t_timestamp  dly_r;
    logic [15:0] width_r;
    logic [11:0] frac_p1;
    logic        carry_p1;
    logic [11:0] pulse_frac_p2;

    logic        latch_en;
    logic        frac_en;
    logic        norm_en;

    logic        start_nxt;
    logic        end_nxt;
    logic        missed_nxt;
    logic        dropped_nxt;
    logic        start_q;
    logic        end_q;
    logic        missed_q;
    logic        dropped_q;

    logic [11:0] frac_sum;
    logic        frac_carry;
    logic [15:0] width_eff;
    logic [28:0] end_offset;

    logic [31:0] start_utc;
    logic [27:0] start_coarse;
    logic [31:0] end_utc;
    logic [27:0] end_coarse;

    logic        at_start;
    logic        past_start;
    logic        at_end;
    logic        past_end;

    function automatic logic [12:0] frac_add(input logic [11:0] a, input logic [11:0] b);
        logic [12:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 13'(g_frac_range))
            return {1'b1, 12'(s - 13'(g_frac_range))};
        return {1'b0, s[11:0]};
    endfunction

    assign {frac_carry, frac_sum} = frac_add(tag_r.frac, dly_r.frac);

    // A zero width still has to produce a one-cycle pulse.
    assign width_eff  = (width_r == 16'd0) ? 16'd1 : width_r;
    assign end_offset = 29'(dly_r.coarse) + 29'(width_eff);

    // ---- stage p2: coarse/UTC normalisation of start and end ----
    timestamp_normalizer #(
        .g_coarse_range (g_coarse_range),
        .g_b_w          (28),
        .g_multi_wrap   (1'b0)
    ) u_start_norm (
        .clk_ref_i  (clk_ref_i),
        .rst_n_i    (rst_n_i),
        .load       (norm_en),
        .a_utc      (tag_r.utc),
        .a_coarse   (tag_r.coarse),
        .b_utc      (dly_r.utc),
        .b_coarse   (dly_r.coarse),
        .carry      (carry_p1),
        .sum_utc    (start_utc),
        .sum_coarse (start_coarse)
    );

    timestamp_normalizer #(
        .g_coarse_range (g_coarse_range),
        .g_b_w          (29),
        .g_multi_wrap   (1'b1)
    ) u_end_norm (
        .clk_ref_i  (clk_ref_i),
        .rst_n_i    (rst_n_i),
        .load       (norm_en),
        .a_utc      (tag_r.utc),
        .a_coarse   (tag_r.coarse),
        .b_utc      (dly_r.utc),
        .b_coarse   (end_offset),
        .carry      (carry_p1),
        .sum_utc    (end_utc),
        .sum_coarse (end_coarse)
    );

    assign at_start   = (bus.cntr_utc_i == start_utc) && (bus.cntr_coarse_i == start_coarse);
    assign past_start = ts_later(bus.cntr_utc_i, bus.cntr_coarse_i, start_utc, start_coarse);
    assign at_end     = (bus.cntr_utc_i == end_utc) && (bus.cntr_coarse_i == end_coarse);
    assign past_end   = ts_later(bus.cntr_utc_i, bus.cntr_coarse_i, end_utc, end_coarse);

    always_comb begin
        state_nxt   = state;
        latch_en    = 1'b0;
        frac_en     = 1'b0;
        norm_en     = 1'b0;
        start_nxt   = 1'b0;
        end_nxt     = 1'b0;
        missed_nxt  = 1'b0;
        dropped_nxt = bus.tag_valid_p1_i && ((state != IDLE) || !bus.enable_i);

        case (state)
            IDLE: begin
                if (bus.enable_i && bus.tag_valid_p1_i) begin
                    latch_en  = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (!bus.enable_i) begin
                    state_nxt = IDLE;
                end else if (!calc_phase) begin
                    frac_en = 1'b1;
                end else begin
                    norm_en   = 1'b1;
                    state_nxt = WAIT_START;
                end
            end
            WAIT_START: begin
                if (!bus.enable_i) begin
                    state_nxt = IDLE;
                end else if (at_start) begin
                    start_nxt = 1'b1;
                    state_nxt = WAIT_END;
                end else if (past_start) begin
                    missed_nxt = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            WAIT_END: begin
                // Once started, a pulse always gets its end strobe.
                if (!bus.enable_i || at_end || past_end) begin
                    end_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_ref_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            calc_phase <= 1'b0;
            start_q    <= 1'b0;
            end_q      <= 1'b0;
            missed_q   <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            calc_phase <= (state == CALC) && (state_nxt == CALC);
            start_q    <= start_nxt;
            end_q      <= end_nxt;
            missed_q   <= missed_nxt;
            dropped_q  <= dropped_nxt;
        end
    end

    // ---- stage p0: latch tag; stage p1: fine-step sum ----
    always_ff @(posedge clk_ref_i) begin
        if (!rst_n_i) begin
            tag_r         <= '0;
            dly_r         <= '0;
            width_r       <= '0;
            frac_p1       <= '0;
            carry_p1      <= 1'b0;
            pulse_frac_p2 <= '0;
        end else begin
            if (latch_en) begin
                tag_r   <= '{utc: bus.tag_utc_i, coarse: bus.tag_coarse_i, frac: bus.tag_frac_i};
                dly_r   <= '{utc: bus.delay_utc_i, coarse: bus.delay_coarse_i, frac: bus.delay_frac_i};
                width_r <= bus.width_i;
            end
            if (frac_en) begin
                frac_p1  <= frac_sum;
                carry_p1 <= frac_carry;
            end
            if (norm_en)
                pulse_frac_p2 <= frac_p1;
        end
    end

    assign bus.pulse_start_p1_o = start_q;
    assign bus.pulse_end_p1_o   = end_q;
    assign bus.missed_p1_o      = missed_q;
    assign bus.dropped_p1_o     = dropped_q;
    assign bus.pulse_frac_o     = pulse_frac_p2;
    assign bus.busy_o           = (state != IDLE);

endmodule

// File: tb/tb_delay_pulse_scheduler.sv
// Directed bench for delay_pulse_scheduler with a 256-cycle second; expected
// strobes are queued with the local time at which they must appear.
module tb_delay_pulse_scheduler;

    localparam int unsigned c_range = 256;
    localparam int K_START   = 0;
    localparam int K_END     = 1;
    localparam int K_MISSED  = 2;
    localparam int K_DROPPED = 3;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] utc;
        logic [27:0] coarse;
        logic [11:0] frac;
    } exp_t;

    logic        clk_ref = 1'b0;
    logic        rst_n   = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;
    exp_t        sb[$];
    logic [31:0] cur_utc;
    logic [27:0] cur_coarse;

    delay_pulse_scheduler_if bus();

    delay_pulse_scheduler #(
        .g_coarse_range (c_range)
    ) dut (
        .clk_ref_i (clk_ref),
        .rst_n_i   (rst_n),
        .bus       (bus)
    );

    always #5 clk_ref = ~clk_ref;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cntr(input logic [31:0] u, input logic [27:0] c);
        cur_utc           = u;
        cur_coarse        = c;
        bus.cntr_utc_i    = u;
        bus.cntr_coarse_i = c;
    endtask

    task automatic push(input string name, input int kind, input logic [31:0] u,
                        input logic [27:0] c, input logic [11:0] f);
        exp_t e;
        e.name   = name;
        e.kind   = kind;
        e.utc    = u;
        e.coarse = c;
        e.frac   = f;
        sb.push_back(e);
    endtask

    // One clock: compare strobes against the queue entries due at the local
    // time seen at this edge, then advance the local time base.
    task automatic tick();
        logic [3:0] exp_v;
        logic [3:0] obs_v;
        @(posedge clk_ref);
        #1;
        exp_v = '0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].utc == bus.cntr_utc_i && sb[i].coarse == bus.cntr_coarse_i) begin
                exp_v[sb[i].kind] = 1'b1;
                if (sb[i].kind == K_START || sb[i].kind == K_END)
                    check({sb[i].name, "_frac"}, bus.pulse_frac_o, sb[i].frac);
                sb.delete(i);
            end
        end
        obs_v = {bus.dropped_p1_o, bus.missed_p1_o, bus.pulse_end_p1_o, bus.pulse_start_p1_o};
        check("strobes", obs_v, exp_v);
        if (cur_coarse == 28'(c_range - 1)) begin
            cur_coarse = '0;
            cur_utc    = cur_utc + 32'd1;
        end else begin
            cur_coarse = cur_coarse + 28'd1;
        end
        bus.cntr_utc_i    = cur_utc;
        bus.cntr_coarse_i = cur_coarse;
    endtask

    task automatic send_tag(input logic [31:0] tu, input logic [27:0] tc, input logic [11:0] tf,
                            input logic [31:0] du, input logic [27:0] dc, input logic [11:0] df,
                            input logic [15:0] w);
        bus.tag_utc_i      = tu;
        bus.tag_coarse_i   = tc;
        bus.tag_frac_i     = tf;
        bus.delay_utc_i    = du;
        bus.delay_coarse_i = dc;
        bus.delay_frac_i   = df;
        bus.width_i        = w;
        bus.tag_valid_p1_i = 1'b1;
        tick();
        bus.tag_valid_p1_i = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int n = 0; n < budget && sb.size() != 0; n++)
            tick();
        check("drain", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic wait_start(input int budget);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            tick();
            seen = bus.pulse_start_p1_o;
        end
        check("start_seen", seen, 1);
    endtask

    initial begin
        bus.enable_i       = 1'b1;
        bus.tag_valid_p1_i = 1'b0;
        bus.tag_utc_i      = '0;
        bus.tag_coarse_i   = '0;
        bus.tag_frac_i     = '0;
        bus.delay_utc_i    = '0;
        bus.delay_coarse_i = '0;
        bus.delay_frac_i   = '0;
        bus.width_i        = '0;
        set_cntr(32'd0, 28'd0);

        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_busy", bus.busy_o, 0);
        check("rst_frac", bus.pulse_frac_o, 0);
        rst_n = 1'b1;
        tick();

        // Basic delay: start (5,30) frac 150, end three cycles later.
        set_cntr(32'd5, 28'd0);
        push("t1_start", K_START, 32'd5, 28'd30, 12'd150);
        push("t1_end",   K_END,   32'd5, 28'd33, 12'd150);
        send_tag(32'd5, 28'd10, 12'd100, 32'd0, 28'd20, 12'd50, 16'd3);
        check("t1_busy", bus.busy_o, 1);
        drain(100);
        check("t1_idle", bus.busy_o, 0);

        // Fine carry into coarse, coarse carry into UTC; width 0 acts as 1.
        set_cntr(32'd5, 28'd200);
        push("t2_start", K_START, 32'd6, 28'd0, 12'd104);
        push("t2_end",   K_END,   32'd6, 28'd1, 12'd104);
        send_tag(32'd5, 28'd250, 12'd4000, 32'd0, 28'd5, 12'd200, 16'd0);
        drain(100);

        // Start only two cycles after the tag strobe: missed.
        set_cntr(32'd7, 28'd100);
        push("t3_missed", K_MISSED, 32'd7, 28'd103, 12'd0);
        send_tag(32'd7, 28'd90, 12'd0, 32'd0, 28'd12, 12'd0, 16'd4);
        drain(20);
        check("t3_busy", bus.busy_o, 0);

        // Second tag while waiting for start is dropped; first pulse unaffected.
        set_cntr(32'd8, 28'd0);
        push("t4_start", K_START, 32'd8, 28'd50, 12'd7);
        push("t4_end",   K_END,   32'd8, 28'd52, 12'd7);
        send_tag(32'd8, 28'd10, 12'd7, 32'd0, 28'd40, 12'd0, 16'd2);
        tick();
        tick();
        push("t4_dropped", K_DROPPED, 32'd8, 28'd3, 12'd0);
        send_tag(32'd8, 28'd20, 12'd0, 32'd0, 28'd1, 12'd0, 16'd1);
        check("t4_busy", bus.busy_o, 1);
        drain(100);

        // Enable dropped one cycle after the start strobe ends the pulse early.
        set_cntr(32'd9, 28'd0);
        push("t5_start", K_START, 32'd9, 28'd10, 12'd5);
        push("t5_end",   K_END,   32'd9, 28'd11, 12'd5);
        send_tag(32'd9, 28'd0, 12'd5, 32'd0, 28'd10, 12'd0, 16'd100);
        wait_start(30);
        bus.enable_i = 1'b0;
        tick();
        bus.enable_i = 1'b1;
        drain(10);
        check("t5_busy", bus.busy_o, 0);

        // Enable low while waiting for start aborts silently.
        set_cntr(32'd10, 28'd0);
        send_tag(32'd10, 28'd0, 12'd0, 32'd0, 28'd50, 12'd0, 16'd1);
        repeat (3) tick();
        bus.enable_i = 1'b0;
        tick();
        bus.enable_i = 1'b1;
        check("t6_busy", bus.busy_o, 0);
        repeat (60) tick();

        // Reset in WAIT_END: no end strobe, everything cleared.
        set_cntr(32'd11, 28'd0);
        push("t7_start", K_START, 32'd11, 28'd10, 12'd10);
        send_tag(32'd11, 28'd0, 12'd9, 32'd0, 28'd10, 12'd1, 16'd50);
        wait_start(30);
        rst_n = 1'b0;
        tick();
        check("t7_end", bus.pulse_end_p1_o, 0);
        check("t7_busy", bus.busy_o, 0);
        check("t7_frac", bus.pulse_frac_o, 0);
        rst_n = 1'b1;
        repeat (70) tick();

        // Local time jumping past the end still produces the end strobe.
        set_cntr(32'd12, 28'd0);
        push("t8_start", K_START, 32'd12, 28'd10, 12'd0);
        push("t8_end",   K_END,   32'd12, 28'd40, 12'd0);
        send_tag(32'd12, 28'd0, 12'd0, 32'd0, 28'd10, 12'd0, 16'd5);
        wait_start(30);
        set_cntr(32'd12, 28'd40);
        drain(10);

        // Tag with enable low in IDLE is dropped and not scheduled.
        set_cntr(32'd13, 28'd0);
        push("t9_dropped", K_DROPPED, 32'd13, 28'd0, 12'd0);
        bus.enable_i = 1'b0;
        send_tag(32'd13, 28'd5, 12'd0, 32'd0, 28'd10, 12'd0, 16'd1);
        bus.enable_i = 1'b1;
        check("t9_busy", bus.busy_o, 0);
        drain(10);
        repeat (20) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
